// File: rtl/wr_arbiter_rr.sv
// Round-robin write arbiter: collects one burst per grant from CH_NUM sources
// into FWFT data/address FIFOs feeding the AXI write master.
module wr_arbiter_rr #(
  parameter int CH_NUM    = 4,
  parameter int DW_IN     = 240,
  parameter int DW_OUT    = 256,
  parameter int ADDR_W    = 16,
  parameter int ADDR_LSB  = 7,
  parameter int BURST_LEN = 16,
  parameter int AF_DEPTH  = 16,
  parameter int DF_DEPTH  = 256,
  parameter int TIMEOUT   = 32
) (
  input  logic                     clk_100M,
  input  logic                     rstn,
  input  logic [CH_NUM-1:0]        ch_req,
  input  logic [CH_NUM-1:0]        ch_vld,
  input  logic [CH_NUM*DW_IN-1:0]  ch_data,
  input  logic [CH_NUM*ADDR_W-1:0] ch_addr,
  output logic [CH_NUM-1:0]        ch_rden,
  output logic                     awaddr_empty,
  input  logic                     awaddr_ref,
  output logic [27:0]              axi_awaddr,
  output logic [3:0]               axi_awlen,
  output logic                     wdata_empty,
  input  logic                     axi_wready,
  output logic [DW_OUT-1:0]        axi_wdata,
  output logic                     err_short,
  output logic [2:0]               err_ch
);

  localparam int CW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BW  = $clog2(BURST_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int AAW = $clog2(AF_DEPTH);
  localparam int DAW = $clog2(DF_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT   = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] PAD     = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  logic [CH_NUM-1:0]        req_q;
  logic [CH_NUM-1:0]        vld_q;
  logic [CH_NUM*DW_IN-1:0]  data_q;
  logic [CH_NUM*ADDR_W-1:0] addr_q;
  logic                     ref_q;

  logic [2:0]        state;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     gnt;
  logic [BW-1:0]     beat_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] addr_lat;

  logic [CW-1:0]     nxt_gnt;
  logic              hit;
  int                rr_j;
  logic              can_grant;
  logic              g_vld;
  logic [DW_IN-1:0]  g_data;
  logic [ADDR_W-1:0] g_addr;

  logic [DW_OUT-1:0] df_mem [DF_DEPTH];
  logic [DAW-1:0]    df_wp;
  logic [DAW-1:0]    df_rp;
  logic [DAW:0]      df_cnt;
  logic [DAW:0]      df_free;
  logic              df_push;
  logic              df_pop;
  logic [DW_OUT-1:0] df_din;

  logic [31:0]       af_mem [AF_DEPTH];
  logic [AAW-1:0]    af_wp;
  logic [AAW-1:0]    af_rp;
  logic [AAW:0]      af_cnt;
  logic              af_push;
  logic              af_pop;
  logic [27:0]       aw_word;

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      req_q  <= '0;
      vld_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      ref_q  <= 1'b0;
    end else begin
      req_q  <= ch_req;
      vld_q  <= ch_vld;
      data_q <= ch_data;
      addr_q <= ch_addr;
      ref_q  <= awaddr_ref;
    end
  end

  // first requester after the last winner, wrapping modulo CH_NUM
  always_comb begin
    nxt_gnt = ptr;
    hit     = 1'b0;
    rr_j    = 0;
    for (int k = 1; k <= CH_NUM; k++) begin
      rr_j = (int'(ptr) + k) % CH_NUM;
      if (!hit && req_q[CW'(rr_j)]) begin
        hit     = 1'b1;
        nxt_gnt = CW'(rr_j);
      end
    end
  end

  assign df_free   = (DAW+1)'(DF_DEPTH) - df_cnt;
  assign can_grant = hit
                   && (af_cnt <= (AAW+1)'(AF_DEPTH - 2))
                   && (df_free >= (DAW+1)'(BURST_LEN));

  assign g_vld  = vld_q[gnt];
  assign g_data = data_q[gnt*DW_IN +: DW_IN];
  assign g_addr = addr_q[gnt*ADDR_W +: ADDR_W];

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= CW'(CH_NUM - 1);
      gnt       <= '0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
      addr_lat  <= '0;
      err_short <= 1'b0;
      err_ch    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (can_grant) begin
            gnt   <= nxt_gnt;
            ptr   <= nxt_gnt;
            state <= GRANT;
          end
        end
        GRANT: begin
          beat_cnt <= '0;
          tmo_cnt  <= '0;
          state    <= COLLECT;
        end
        COLLECT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (g_vld) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == '0) addr_lat <= g_addr;
          end
          if (g_vld && beat_cnt == BW'(BURST_LEN - 1))
            state <= COMMIT;
          else if (tmo_cnt == TW'(TIMEOUT - 1))
            state <= PAD;
        end
        PAD: begin
          beat_cnt  <= beat_cnt + 1'b1;
          err_short <= 1'b1;
          err_ch    <= 3'(gnt);
          if (beat_cnt == BW'(BURST_LEN - 1)) state <= COMMIT;
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ch_rden = '0;
    if (state == GRANT) ch_rden[gnt] = 1'b1;
  end

  assign df_push = (state == COLLECT && g_vld) || state == PAD;
  assign df_din  = (state == PAD) ? '0 : DW_OUT'(g_data);
  assign df_pop  = axi_wready && df_cnt != '0;

  always_ff @(posedge clk_100M) begin
    if (df_push) df_mem[df_wp] <= df_din;
  end

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      df_wp  <= '0;
      df_rp  <= '0;
      df_cnt <= '0;
    end else begin
      if (df_push) df_wp <= df_wp + 1'b1;
      if (df_pop)  df_rp <= df_rp + 1'b1;
      unique case ({df_push, df_pop})
        2'b10:   df_cnt <= df_cnt + 1'b1;
        2'b01:   df_cnt <= df_cnt - 1'b1;
        default: df_cnt <= df_cnt;
      endcase
    end
  end

  // address goes in only after its full burst of data
  assign aw_word = 28'(addr_lat) << ADDR_LSB;
  assign af_push = state == COMMIT;
  assign af_pop  = awaddr_ref && !ref_q && af_cnt != '0;

  always_ff @(posedge clk_100M) begin
    if (af_push) af_mem[af_wp] <= {4'(BURST_LEN - 1), aw_word};
  end

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      af_wp  <= '0;
      af_rp  <= '0;
      af_cnt <= '0;
    end else begin
      if (af_push)
        af_wp <= (af_wp == AAW'(AF_DEPTH - 1)) ? '0 : af_wp + 1'b1;
      if (af_pop)
        af_rp <= (af_rp == AAW'(AF_DEPTH - 1)) ? '0 : af_rp + 1'b1;
      unique case ({af_push, af_pop})
        2'b10:   af_cnt <= af_cnt + 1'b1;
        2'b01:   af_cnt <= af_cnt - 1'b1;
        default: af_cnt <= af_cnt;
      endcase
    end
  end

  assign wdata_empty  = df_cnt == '0;
  assign awaddr_empty = af_cnt == '0;
  assign axi_wdata    = wdata_empty  ? '0 : df_mem[df_rp];
  assign axi_awaddr   = awaddr_empty ? '0 : af_mem[af_rp][27:0];
  assign axi_awlen    = awaddr_empty ? '0 : af_mem[af_rp][31:28];

endmodule
